// File: rtl/cpu_pkg.sv
// Shared types for the register-file write path.
package cpu_pkg;
   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef enum logic {NORM = 1'b0, FORCE = 1'b1} arb_state_e;

   localparam reg_addr_t REG_ZERO = 5'd0;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } uart_entry_t;

   function automatic word_t onehot_addr(input reg_addr_t a);
      return word_t'(1) << a;
   endfunction
endpackage

// File: rtl/regwrite_fifo.sv
// Small synchronous FIFO of UART register writes; exposes per-slot valid and
// address so the top can build the pending-write mask.
module regwrite_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  uart_entry_t             wr_entry,
   output uart_entry_t             rd_entry,
   output logic                    full,
   output logic                    empty,
   output logic [DEPTH-1:0]        slot_valid,
   output reg_addr_t [DEPTH-1:0]   slot_addr
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   uart_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;
   logic [PTR_W-1:0]   offs;
   logic               do_push, do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      offs       = '0;
      slot_valid = '0;
      slot_addr  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs          = PTR_W'(i) - rd_ptr;
         slot_valid[i] = ({1'b0, offs} < count);
         slot_addr[i]  = mem[i].addr;
      end
   end
endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write port arbiter: pipeline writeback first, buffered UART
// results fill idle slots, with a forced UART slot after a long writeback streak.
//
// state | meaning
// NORM  | writeback has priority, FIFO drains into idle slots
// FORCE | one cycle: FIFO head granted, any writeback is dropped
module regwrite_arbiter
   import cpu_pkg::*;
#(
   parameter int FIFO_DEPTH    = 2,
   parameter int MAX_WB_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        uart_valid,
   input  logic [4:0]  uart_addr,
   input  logic [31:0] uart_data,
   output logic        uart_ready,
   output logic        RegWrite,
   output logic [4:0]  address,
   output logic [31:0] data,
   output logic        stall_req,
   output logic [31:0] pending_mask,
   output logic        proto_err
);
   localparam int STREAK_W = $clog2(MAX_WB_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WB_STREAK);

   arb_state_e                 state_q, state_d;
   logic [STREAK_W-1:0]        streak_q, streak_d;
   logic                       fifo_full, fifo_empty, push, pop;
   logic [FIFO_DEPTH-1:0]      slot_valid;
   reg_addr_t [FIFO_DEPTH-1:0] slot_addr;
   uart_entry_t                head;
   logic                       wr_en_d, proto_err_d;
   reg_addr_t                  wr_addr_d;
   word_t                      wr_data_d;

   assign uart_ready = !fifo_full;
   assign push       = uart_valid && !fifo_full && (uart_addr != REG_ZERO);

   regwrite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .wr_entry   ({uart_addr, uart_data}),
      .rd_entry   (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .slot_valid (slot_valid),
      .slot_addr  (slot_addr)
   );

   always_comb begin
      state_d     = NORM;
      streak_d    = streak_q;
      pop         = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = address;
      wr_data_d   = data;
      proto_err_d = proto_err;
      if (state_q == FORCE) begin
         pop         = !fifo_empty;
         wr_en_d     = !fifo_empty;
         wr_addr_d   = head.addr;
         wr_data_d   = head.data;
         proto_err_d = proto_err || wb_valid;
         streak_d    = '0;
      end else if (wb_valid) begin
         wr_en_d   = (wb_addr != REG_ZERO);
         wr_addr_d = wb_addr;
         wr_data_d = wb_data;
         // No pop on a writeback grant, so the FIFO is non-empty afterwards
         // if it already held data or takes a push this cycle.
         if (!fifo_empty || push) begin
            streak_d = streak_q + 1'b1;
            if (streak_d == STREAK_MAX) state_d = FORCE;
         end else begin
            streak_d = '0;
         end
      end else if (!fifo_empty) begin
         pop       = 1'b1;
         wr_en_d   = 1'b1;
         wr_addr_d = head.addr;
         wr_data_d = head.data;
         streak_d  = '0;
      end else begin
         streak_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= NORM;
         streak_q  <= '0;
         RegWrite  <= 1'b0;
         address   <= '0;
         data      <= '0;
         stall_req <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         RegWrite  <= wr_en_d;
         address   <= wr_addr_d;
         data      <= wr_data_d;
         stall_req <= (state_d == FORCE);
         proto_err <= proto_err_d;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (slot_valid[i]) pending_mask = pending_mask | onehot_addr(slot_addr[i]);
      end
   end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: vector table for writeback
// latency plus scripted UART, forced-slot and reset sequences.
module tb_regwrite_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        uart_valid;
   logic [4:0]  uart_addr;
   logic [31:0] uart_data;
   logic        uart_ready;
   logic        RegWrite;
   logic [4:0]  address;
   logic [31:0] data;
   logic        stall_req;
   logic [31:0] pending_mask;
   logic        proto_err;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        exp_rw;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } wb_vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wb_vec_t vec [6];
   wr_t     exp_q [$];
   wr_t     sb_e;

   regwrite_arbiter #(.FIFO_DEPTH(2), .MAX_WB_STREAK(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .uart_valid   (uart_valid),
      .uart_addr    (uart_addr),
      .uart_data    (uart_data),
      .uart_ready   (uart_ready),
      .RegWrite     (RegWrite),
      .address      (address),
      .data         (data),
      .stall_req    (stall_req),
      .pending_mask (pending_mask),
      .proto_err    (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic uv, input logic [4:0] ua, input logic [31:0] ud);
      wb_valid   = wv;
      wb_addr    = wa;
      wb_data    = wd;
      uart_valid = uv;
      uart_addr  = ua;
      uart_data  = ud;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every register-file write must match the next expected one.
   always @(negedge clk) begin
      if (!reset && RegWrite) begin
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL sb_unexpected_write: got addr %0d data %h, expected no write", address, data);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_addr", 32'(address), 32'(sb_e.a));
            check("sb_data", data, sb_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  32'h12345678};
      vec[1] = '{1'b0, 5'd9,  32'h0000DEAD, 1'b0, 5'd0,  32'h0};
      vec[2] = '{1'b1, 5'd0,  32'h0000CAFE, 1'b0, 5'd0,  32'h0};
      vec[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
      vec[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
      vec[5] = '{1'b0, 5'd2,  32'h00000002, 1'b0, 5'd0,  32'h0};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_regwrite",  32'(RegWrite),  32'd0);
      check("rst_uart_ready", 32'(uart_ready), 32'd1);
      check("rst_pending",   pending_mask,   32'd0);
      check("rst_stall",     32'(stall_req), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);

      // writeback vectors, FIFO empty
      for (int i = 0; i < 6; i++) begin
         drive(vec[i].wv, vec[i].wa, vec[i].wd, 0, 0, 0);
         if (vec[i].exp_rw) expect_wr(vec[i].exp_addr, vec[i].exp_data);
         step();
         check($sformatf("vec%0d_regwrite", i), 32'(RegWrite), 32'(vec[i].exp_rw));
         if (vec[i].exp_rw) begin
            check($sformatf("vec%0d_addr", i), 32'(address), 32'(vec[i].exp_addr));
            check($sformatf("vec%0d_data", i), data, vec[i].exp_data);
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("vec_idle_regwrite", 32'(RegWrite), 32'd0);

      // single UART entry drains into an idle slot
      drive(0, 0, 0, 1, 5'd5, 32'h41);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check("uart_pending", pending_mask, 32'h20);
      expect_wr(5'd5, 32'h41);
      step();
      check("uart_regwrite", 32'(RegWrite), 32'd1);
      check("uart_addr", 32'(address), 32'd5);
      check("uart_data", data, 32'h41);
      check("uart_pending_clr", pending_mask, 32'd0);

      // fill FIFO under a writeback streak, then forced slot
      drive(1, 5'd10, 32'hA0A00010, 1, 5'd6, 32'h66);
      expect_wr(5'd10, 32'hA0A00010);
      step();
      drive(1, 5'd11, 32'hA0A00011, 1, 5'd7, 32'h77);
      expect_wr(5'd11, 32'hA0A00011);
      step();
      check("full_ready", 32'(uart_ready), 32'd0);
      check("full_pending", pending_mask, 32'hC0);
      drive(1, 5'd12, 32'hA0A00012, 1, 5'd8, 32'h88);
      expect_wr(5'd12, 32'hA0A00012);
      step();
      check("full_ready2", 32'(uart_ready), 32'd0);
      check("full_pending2", pending_mask, 32'hC0);
      check("streak3_stall", 32'(stall_req), 32'd0);
      drive(1, 5'd13, 32'hA0A00013, 0, 0, 0);
      expect_wr(5'd13, 32'hA0A00013);
      step();
      check("streak4_stall", 32'(stall_req), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      expect_wr(5'd6, 32'h66);
      step();
      check("force_addr", 32'(address), 32'd6);
      check("force_stall_clr", 32'(stall_req), 32'd0);
      check("force_proto_ok", 32'(proto_err), 32'd0);
      check("force_ready", 32'(uart_ready), 32'd1);
      expect_wr(5'd7, 32'h77);
      step();
      check("drain_addr", 32'(address), 32'd7);
      check("drain_pending", pending_mask, 32'd0);
      step();
      check("drain_idle", 32'(RegWrite), 32'd0);

      // forced slot with wb_valid still high: protocol error
      drive(1, 5'd14, 32'hB0000014, 1, 5'd9, 32'h99);
      expect_wr(5'd14, 32'hB0000014);
      step();
      for (int k = 15; k <= 17; k++) begin
         drive(1, 5'(k), 32'hB0000000 + 32'(k), 0, 0, 0);
         expect_wr(5'(k), 32'hB0000000 + 32'(k));
         step();
      end
      check("perr_stall", 32'(stall_req), 32'd1);
      drive(1, 5'd18, 32'h00000BAD, 0, 0, 0);
      expect_wr(5'd9, 32'h99);
      step();
      check("perr_set", 32'(proto_err), 32'd1);
      check("perr_addr", 32'(address), 32'd9);
      drive(0, 0, 0, 0, 0, 0);
      step();
      check("perr_sticky", 32'(proto_err), 32'd1);
      check("perr_dropped", 32'(RegWrite), 32'd0);

      // UART to r0 is discarded
      drive(0, 0, 0, 1, 5'd0, 32'h55);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check("r0_pending", pending_mask, 32'd0);
      check("r0_ready", 32'(uart_ready), 32'd1);
      step();
      check("r0_no_write", 32'(RegWrite), 32'd0);

      // async reset mid-operation kills the in-flight write and the FIFO
      drive(1, 5'd22, 32'hC0000022, 1, 5'd20, 32'h2020);
      expect_wr(5'd22, 32'hC0000022);
      step();
      drive(1, 5'd23, 32'hC0000023, 1, 5'd21, 32'h2121);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check("prerst_pending", pending_mask, 32'h00300000);
      #1 reset = 1'b1;
      #1;
      check("arst_regwrite", 32'(RegWrite), 32'd0);
      check("arst_pending", pending_mask, 32'd0);
      check("arst_ready", 32'(uart_ready), 32'd1);
      check("arst_proto", 32'(proto_err), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step();
      step();
      check("postrst_no_write", 32'(RegWrite), 32'd0);
      check("postrst_pending", pending_mask, 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
